// File: rtl/wb_load_merge.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_merge
// Purpose  : Writeback load merger. Takes one load descriptor, collects one
//            memory read beat (or two when a misaligned access crosses a beat
//            boundary), then slices, sign/zero-extends and issues a single
//            registered register-file write. busy_o stalls the pipeline.
// Macro    : WB_LOAD_MERGE_MISALIGN_EN - when defined, beat-crossing accesses
//            take a second beat (WAIT1 state, beat1_req_o). When undefined,
//            any crossing or non-naturally-aligned access faults instead.
// Ports    : clk_i, rst_i (async, active-high)
//            req_*   : load descriptor handshake and fields
//            beat_*  : memory read beats
//            beat1_req_o : pulse requesting the next aligned beat
//            rd_*    : register-file write (data, index, strobe)
//            fault_o : pulse on illegal/unsupported access
//            busy_o  : high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module wb_load_merge #(
    parameter int XLEN   = 64,
    parameter int OFFS_W = $clog2(XLEN/8)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [4:0]        req_rd_idx_i,
    input  logic [3:0]        req_width_1h_i,
    input  logic              req_sign_i,
    input  logic [OFFS_W-1:0] req_byte_addr_i,
    input  logic              beat_valid_i,
    input  logic [XLEN-1:0]   beat_data_i,
    output logic              beat1_req_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic [4:0]        rd_idx_o,
    output logic              rd_wr_en_o,
    output logic              fault_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT0 = 3'd1,
        S_WAIT1 = 3'd2,
        S_WRITE = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          rd_idx_q, rd_idx_d;
    logic [3:0]          nbytes_q, nbytes_d;
    logic                sign_q, sign_d;
    logic [OFFS_W-1:0]   offs_q, offs_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic                beat1_req_q, beat1_req_d;
`ifdef WB_LOAD_MERGE_MISALIGN_EN
    logic                cross_q, cross_d;
    logic [XLEN-1:0]     beat0_q, beat0_d;
`endif

    // Descriptor decode
    logic [3:0]          req_nbytes;
    logic                req_legal;
    logic [4:0]          req_end;
    logic                req_cross;
    logic                req_misalign;

    always_comb begin
        req_nbytes = 4'd1;
        req_legal  = 1'b0;
        case (req_width_1h_i)
            4'b0001: begin req_nbytes = 4'd1; req_legal = 1'b1; end
            4'b0010: begin req_nbytes = 4'd2; req_legal = 1'b1; end
            4'b0100: begin req_nbytes = 4'd4; req_legal = 1'b1; end
            4'b1000: begin req_nbytes = 4'd8; req_legal = (XLEN == 64); end
            default: begin req_nbytes = 4'd1; req_legal = 1'b0; end
        endcase
    end

    assign req_end      = 5'(req_byte_addr_i) + 5'(req_nbytes);
    assign req_cross    = (req_end > 5'(XLEN/8));
    assign req_misalign = ((4'(req_byte_addr_i) & (req_nbytes - 4'd1)) != 4'd0);

    // Merge: low half is beat0, high half is beat1 (zero unless crossing).
    // In WAIT1 the stored beat0 pairs with the incoming beat1; in WAIT0 the
    // incoming beat is beat0 and beat1 is absent.
    logic [XLEN-1:0]     merge_lo, merge_hi;
    logic [OFFS_W+2:0]   merge_shamt;
    logic [XLEN-1:0]     merge_shifted;
    logic                merge_ext;
    logic [XLEN-1:0]     merge_data;

`ifdef WB_LOAD_MERGE_MISALIGN_EN
    assign merge_lo = (state_q == S_WAIT1) ? beat0_q     : beat_data_i;
    assign merge_hi = (state_q == S_WAIT1) ? beat_data_i : '0;
`else
    assign merge_lo = beat_data_i;
    assign merge_hi = '0;
`endif

    assign merge_shamt   = {offs_q, 3'b000};
    assign merge_shifted = XLEN'({merge_hi, merge_lo} >> merge_shamt);

    always_comb begin
        merge_ext = 1'b0;
        case (nbytes_q)
            4'd1:    merge_ext = sign_q & merge_shifted[7];
            4'd2:    merge_ext = sign_q & merge_shifted[15];
            4'd4:    merge_ext = sign_q & merge_shifted[31];
            default: merge_ext = 1'b0;   // double: never extended
        endcase
    end

    always_comb begin
        merge_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            merge_data[i] = (i < 8 * int'(nbytes_q)) ? merge_shifted[i] : merge_ext;
        end
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        nbytes_d    = nbytes_q;
        sign_d      = sign_q;
        offs_d      = offs_q;
        rd_data_d   = rd_data_q;
        beat1_req_d = 1'b0;
`ifdef WB_LOAD_MERGE_MISALIGN_EN
        cross_d     = cross_q;
        beat0_d     = beat0_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    rd_idx_d = req_rd_idx_i;
                    nbytes_d = req_nbytes;
                    sign_d   = req_sign_i;
                    offs_d   = req_byte_addr_i;
`ifdef WB_LOAD_MERGE_MISALIGN_EN
                    cross_d  = req_cross;
                    state_d  = req_legal ? S_WAIT0 : S_FAULT;
`else
                    state_d  = (req_legal && !req_cross && !req_misalign)
                               ? S_WAIT0 : S_FAULT;
`endif
                end
            end
            S_WAIT0: begin
                if (beat_valid_i) begin
`ifdef WB_LOAD_MERGE_MISALIGN_EN
                    beat0_d = beat_data_i;
                    if (cross_q) begin
                        beat1_req_d = 1'b1;
                        state_d     = S_WAIT1;
                    end else begin
                        rd_data_d = merge_data;
                        state_d   = S_WRITE;
                    end
`else
                    rd_data_d = merge_data;
                    state_d   = S_WRITE;
`endif
                end
            end
`ifdef WB_LOAD_MERGE_MISALIGN_EN
            S_WAIT1: begin
                if (beat_valid_i) begin
                    rd_data_d = merge_data;
                    state_d   = S_WRITE;
                end
            end
`endif
            S_WRITE: state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rd_idx_q    <= '0;
            nbytes_q    <= 4'd1;
            sign_q      <= 1'b0;
            offs_q      <= '0;
            rd_data_q   <= '0;
            beat1_req_q <= 1'b0;
`ifdef WB_LOAD_MERGE_MISALIGN_EN
            cross_q     <= 1'b0;
            beat0_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            nbytes_q    <= nbytes_d;
            sign_q      <= sign_d;
            offs_q      <= offs_d;
            rd_data_q   <= rd_data_d;
            beat1_req_q <= beat1_req_d;
`ifdef WB_LOAD_MERGE_MISALIGN_EN
            cross_q     <= cross_d;
            beat0_q     <= beat0_d;
`endif
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign rd_wr_en_o  = (state_q == S_WRITE);
    assign fault_o     = (state_q == S_FAULT);
    assign rd_data_o   = rd_data_q;
    assign rd_idx_o    = rd_wr_en_o ? rd_idx_q : 5'd0;
`ifdef WB_LOAD_MERGE_MISALIGN_EN
    assign beat1_req_o = beat1_req_q;
`else
    assign beat1_req_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_load_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_load_merge
// Purpose  : Directed self-checking bench for wb_load_merge. Drives one
//            XLEN=64 and one XLEN=32 instance with hand-computed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_load_merge;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // XLEN=64 instance
    logic        a_req_valid, a_req_ready, a_sign, a_beat_valid, a_beat1_req;
    logic        a_wr_en, a_fault, a_busy;
    logic [4:0]  a_rd_idx_in, a_rd_idx;
    logic [3:0]  a_width;
    logic [2:0]  a_addr;
    logic [63:0] a_beat_data, a_rd_data;

    // XLEN=32 instance
    logic        b_req_valid, b_req_ready, b_sign, b_beat_valid, b_beat1_req;
    logic        b_wr_en, b_fault, b_busy;
    logic [4:0]  b_rd_idx_in, b_rd_idx;
    logic [3:0]  b_width;
    logic [1:0]  b_addr;
    logic [31:0] b_beat_data, b_rd_data;

    wb_load_merge #(.XLEN(64)) u_dut64 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_rd_idx_i(a_rd_idx_in), .req_width_1h_i(a_width),
        .req_sign_i(a_sign), .req_byte_addr_i(a_addr),
        .beat_valid_i(a_beat_valid), .beat_data_i(a_beat_data),
        .beat1_req_o(a_beat1_req), .rd_data_o(a_rd_data), .rd_idx_o(a_rd_idx),
        .rd_wr_en_o(a_wr_en), .fault_o(a_fault), .busy_o(a_busy)
    );

    wb_load_merge #(.XLEN(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_rd_idx_i(b_rd_idx_in), .req_width_1h_i(b_width),
        .req_sign_i(b_sign), .req_byte_addr_i(b_addr),
        .beat_valid_i(b_beat_valid), .beat_data_i(b_beat_data),
        .beat1_req_o(b_beat1_req), .rd_data_o(b_rd_data), .rd_idx_o(b_rd_idx),
        .rd_wr_en_o(b_wr_en), .fault_o(b_fault), .busy_o(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a descriptor for one cycle; returns after the accept edge.
    task automatic req64(input logic [3:0] w, input logic s, input logic [2:0] off,
                         input logic [4:0] rd);
        a_req_valid = 1'b1; a_width = w; a_sign = s; a_addr = off; a_rd_idx_in = rd;
        tick();
        a_req_valid = 1'b0;
    endtask

    task automatic beat64(input logic [63:0] d);
        a_beat_valid = 1'b1; a_beat_data = d;
        tick();
        a_beat_valid = 1'b0;
    endtask

    task automatic req32(input logic [3:0] w, input logic s, input logic [1:0] off,
                         input logic [4:0] rd);
        b_req_valid = 1'b1; b_width = w; b_sign = s; b_addr = off; b_rd_idx_in = rd;
        tick();
        b_req_valid = 1'b0;
    endtask

    task automatic beat32(input logic [31:0] d);
        b_beat_valid = 1'b1; b_beat_data = d;
        tick();
        b_beat_valid = 1'b0;
    endtask

    initial begin
        a_req_valid = 0; a_width = 0; a_sign = 0; a_addr = 0; a_rd_idx_in = 0;
        a_beat_valid = 0; a_beat_data = 0;
        b_req_valid = 0; b_width = 0; b_sign = 0; b_addr = 0; b_rd_idx_in = 0;
        b_beat_valid = 0; b_beat_data = 0;

        tick(); tick();
        // Reset state
        chk("rst_ready",  {63'd0, a_req_ready}, 64'd1);
        chk("rst_busy",   {63'd0, a_busy},      64'd0);
        chk("rst_wr_en",  {63'd0, a_wr_en},     64'd0);
        chk("rst_fault",  {63'd0, a_fault},     64'd0);
        chk("rst_b1req",  {63'd0, a_beat1_req}, 64'd0);
        chk("rst_data",   a_rd_data,            64'd0);
        rst = 1'b0;
        tick();

        // Byte signed, offset 5, rd 7
        req64(4'b0001, 1'b1, 3'd5, 5'd7);
        chk("lb_busy",   {63'd0, a_busy},      64'd1);
        chk("lb_ready",  {63'd0, a_req_ready}, 64'd0);
        chk("lb_nowr",   {63'd0, a_wr_en},     64'd0);
        beat64(64'h0011_8022_3344_5566);
        chk("lb_wr_en",  {63'd0, a_wr_en},     64'd1);
        chk("lb_data",   a_rd_data,            64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_idx",    {59'd0, a_rd_idx},    64'd7);
        tick();
        chk("lb_wr_off", {63'd0, a_wr_en},     64'd0);
        chk("lb_hold",   a_rd_data,            64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_idle",   {63'd0, a_req_ready}, 64'd1);

        // Word unsigned, offset 4, rd 0 (strobe still pulsed)
        req64(4'b0100, 1'b0, 3'd4, 5'd0);
        beat64(64'h8765_4321_0000_0000);
        chk("lwu_wr_en", {63'd0, a_wr_en},     64'd1);
        chk("lwu_data",  a_rd_data,            64'h0000_0000_8765_4321);
        chk("lwu_idx",   {59'd0, a_rd_idx},    64'd0);
        tick();

        // Double signed is never extended
        req64(4'b1000, 1'b1, 3'd0, 5'd9);
        beat64(64'h8000_0000_0000_0001);
        chk("ld_data",   a_rd_data,            64'h8000_0000_0000_0001);
        chk("ld_idx",    {59'd0, a_rd_idx},    64'd9);
        tick();

        // Half signed, offset 7: crosses the beat boundary
        req64(4'b0010, 1'b1, 3'd7, 5'd4);
`ifdef WB_LOAD_MERGE_MISALIGN_EN
        chk("lh7_nofault", {63'd0, a_fault},   64'd0);
        beat64(64'hAB00_0000_0000_0000);
        chk("lh7_b1req",   {63'd0, a_beat1_req}, 64'd1);
        chk("lh7_nowr",    {63'd0, a_wr_en},   64'd0);
        beat64(64'h0000_0000_0000_00CD);
        chk("lh7_b1off",   {63'd0, a_beat1_req}, 64'd0);
        chk("lh7_wr_en",   {63'd0, a_wr_en},   64'd1);
        chk("lh7_data",    a_rd_data,          64'hFFFF_FFFF_FFFF_CDAB);
        tick();
`else
        chk("lh7_fault",   {63'd0, a_fault},   64'd1);
        chk("lh7_nowr",    {63'd0, a_wr_en},   64'd0);
        tick();
        chk("lh7_fault_off", {63'd0, a_fault}, 64'd0);
        chk("lh7_ready",   {63'd0, a_req_ready}, 64'd1);
        chk("lh7_nowr2",   {63'd0, a_wr_en},   64'd0);
        // Non-crossing but misaligned half also faults
        req64(4'b0010, 1'b0, 3'd1, 5'd4);
        chk("lh1_fault",   {63'd0, a_fault},   64'd1);
        tick();
`endif

        // Illegal width 0110, then a stray beat in IDLE is dropped
        req64(4'b0110, 1'b0, 3'd0, 5'd3);
        chk("w0110_fault", {63'd0, a_fault},   64'd1);
        chk("w0110_nowr",  {63'd0, a_wr_en},   64'd0);
        tick();
        chk("w0110_ready", {63'd0, a_req_ready}, 64'd1);
        beat64(64'h1234_5678_9ABC_DEF0);
        chk("stray_busy",  {63'd0, a_busy},    64'd0);
        chk("stray_nowr",  {63'd0, a_wr_en},   64'd0);
        chk("stray_hold",  a_rd_data,          64'hFFFF_FFFF_FFFF_CDAB
`ifndef WB_LOAD_MERGE_MISALIGN_EN
                                               ^ 64'h7FFF_FFFF_FFFF_CDAA
`endif
           );

        // XLEN=32: double width is illegal
        beat32(32'hDEAD_BEEF);                 // stray beat in IDLE
        chk("x32_stray",   {63'd0, b_busy},    64'd0);
        req32(4'b1000, 1'b0, 2'd0, 5'd1);
        chk("x32_d_fault", {63'd0, b_fault},   64'd1);
        chk("x32_d_nowr",  {63'd0, b_wr_en},   64'd0);
        tick();
        chk("x32_ready",   {63'd0, b_req_ready}, 64'd1);
        // XLEN=32: word signed fills the full register, no extension bits
        req32(4'b0100, 1'b1, 2'd0, 5'd2);
        beat32(32'h8000_0001);
        chk("x32_lw",      {32'd0, b_rd_data}, 64'h8000_0001);
        tick();
        // XLEN=32: half signed, offset 2
        req32(4'b0010, 1'b1, 2'd2, 5'd5);
        beat32(32'h9ABC_0000);
        chk("x32_lh",      {32'd0, b_rd_data}, 64'hFFFF_9ABC);
        chk("x32_lh_idx",  {59'd0, b_rd_idx},  64'd5);
        tick();

        // Reset mid-operation
`ifdef WB_LOAD_MERGE_MISALIGN_EN
        req64(4'b0010, 1'b1, 3'd7, 5'd4);
        beat64(64'hAB00_0000_0000_0000);      // now in WAIT1
`else
        req64(4'b0100, 1'b0, 3'd0, 5'd4);     // now in WAIT0
`endif
        chk("mid_busy",    {63'd0, a_busy},    64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {63'd0, a_req_ready}, 64'd1);
        chk("mid_rst_busy",  {63'd0, a_busy},  64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_beat_valid = 1'b1; a_beat_data = 64'h0000_0000_0000_00CD;
            tick();
            chk("post_rst_nowr",  {63'd0, a_wr_en}, 64'd0);
            chk("post_rst_nofault", {63'd0, a_fault}, 64'd0);
        end
        a_beat_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_load_merge.md
Name: wb_load_merge

Overview:
- Parametrised successor to the writeback load slicer.
- Accepts one load descriptor at a time and collects one or two memory read beats. A misaligned access that crosses a beat boundary takes two beats.
- Merges, slices and sign/zero-extends the loaded bytes, then issues a single registered register-file write.
- Sits between the data-memory response path and the register file write port; stalls the pipeline through busy_o.

Parameters:
- XLEN, 64, data and beat width in bits; legal values 32 or 64.
- OFFS_W, $clog2(XLEN/8), byte-offset width; derived, not overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  load descriptor valid
- req_ready_o  out  1  block can accept a descriptor (state IDLE)
- req_rd_idx_i  in  5  destination register
- req_width_1h_i  in  4  one-hot width: 0001 byte, 0010 half, 0100 word, 1000 double
- req_sign_i  in  1  1 = sign-extend, 0 = zero-extend
- req_byte_addr_i  in  OFFS_W  byte offset within the beat
- beat_valid_i  in  1  memory read beat valid
- beat_data_i  in  XLEN  memory read data
- beat1_req_o  out  1  one-cycle pulse: request the next aligned beat (address + XLEN/8)
- rd_data_o  out  XLEN  write data
- rd_idx_o  out  5  write index
- rd_wr_en_o  out  1  one-cycle write strobe
- fault_o  out  1  one-cycle pulse: illegal or unsupported access
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0 except req_ready_o=1; beat0 register cleared.
- Descriptor accepted when req_valid_i && req_ready_o. Fields are latched.
- Access size: nbytes = 1/2/4/8 from the one-hot width. cross = (offset + nbytes > XLEN/8).
- Illegal width (non-one-hot, 0000, or 1000 with XLEN=32): fault_o pulses on the cycle after accept; no write; return to IDLE. No beats are consumed.
- States:
  - IDLE -> WAIT0 on accept (legal width).
  - WAIT0: on beat_valid_i, latch beat0. If !cross -> WRITE. If cross -> pulse beat1_req_o, go to WAIT1.
  - WAIT1: on beat_valid_i, latch beat1 -> WRITE.
  - WRITE: assert rd_wr_en_o, rd_data_o and rd_idx_o for exactly one cycle -> IDLE.
- Merge: concatenate {beat1, beat0} (2*XLEN bits; beat1 = 0 when !cross), right-shift by offset*8, take the low nbytes*8 bits.
  - Extension bit = req_sign_i ? top bit of the slice : 0.
  - Double loads are never extended.
- Latency:
  - Aligned: write strobe 1 cycle after the beat-0 cycle.
  - Crossing: write strobe 1 cycle after the beat-1 cycle.
- beat_valid_i in IDLE or WRITE is ignored (dropped).
- Writes to rd_idx 0: rd_wr_en_o is still pulsed; the register file discards them.
- rd_data_o holds its last value when rd_wr_en_o=0.
- Reset mid-operation: state returns to IDLE immediately; no write or fault is emitted for the aborted load.
- req_ready_o is combinational from state only (no dependency on req_valid_i).

Optional Feature:
- Macro: WB_LOAD_MERGE_MISALIGN_EN.
- Defined: crossing accesses are handled with two beats as described above.
- Undefined: states WAIT1 and beat1_req_o logic are removed (beat1_req_o tied to 0).
  - Any access with cross=1, or offset not a multiple of nbytes, pulses fault_o the cycle after accept.
  - No beat is consumed and no write is made.
  - Aligned behaviour is unchanged.

Test Plan:
- XLEN=64. Load byte signed, offset 5, rd=7; beat 0x0011_8022_3344_5566 -> rd_wr_en_o one cycle later, rd_data_o=0xFFFF_FFFF_FFFF_FF80, rd_idx_o=7.
- Word unsigned, offset 4; beat 0x8765_4321_0000_0000 -> rd_data_o=0x0000_0000_8765_4321.
- Misalign enabled. Half signed, offset 7; beat0 0xAB00_0000_0000_0000 -> beat1_req_o pulse; beat1 0x0000_0000_0000_00CD -> rd_data_o=0xFFFF_FFFF_FFFF_CDAB.
- Misalign disabled. Same half/offset 7 request -> fault_o pulse the cycle after accept, rd_wr_en_o never asserted, req_ready_o=1 the following cycle.
- Width 0110 -> fault_o pulse. XLEN=32 with width 1000 -> fault_o pulse. In both cases any beat_valid_i in IDLE is ignored.
- Assert rst_i while in WAIT1 -> req_ready_o=1 and busy_o=0 immediately; no rd_wr_en_o or fault_o afterwards.
